reduced_divider: RTL and testbench

- Multi-cycle signed divider that sequences one shared `log2` leading-one unit.
- It measures operand magnitudes, then pre-shifts numerator and denominator so the divisor keeps at most DBITS significant bits.
- It then runs a restoring division that skips the numerator's leading zeros.
- It sits between the projection/geometry math and the pixel pipeline; it replaces wide combinational dividers.

---
 rtl/div_pkg.sv | 11 +
 rtl/log2.sv | 14 +
 rtl/reduced_divider.sv | 114 +++++++++++
 tb/tb_reduced_divider.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared constants, FSM states and pre-shift helper for reduced_divider.
package div_pkg;
    localparam int DIV_WIDTH = 20;
    localparam int DIV_DBITS = 8;
    localparam logic [DIV_WIDTH-1:0] MAX_POS = {1'b0, {(DIV_WIDTH-1){1'b1}}};
    localparam logic [DIV_WIDTH-1:0] MAX_NEG = {1'b1, {(DIV_WIDTH-1){1'b0}}};
    typedef enum logic [2:0] {IDLE, LOGD, LOGN, DIV, FIN, HOLD} state_t;
    function automatic int shift_amt(input int e, input int dbits);
        return (e > dbits) ? e - dbits : 0;
    endfunction
endpackage

// File: rtl/log2.sv
// log2: bit length of an unsigned value (0 for zero).
module log2 #(
    parameter int W  = 20,
    parameter int EW = $clog2(W + 1)
) (
    input  logic [W-1:0]  x_i,
    output logic [EW-1:0] e_o
);
    always_comb begin
        e_o = '0;
        for (int i = 0; i < W; i++)
            if (x_i[i]) e_o = EW'(i + 1);
    end
endmodule

// File: rtl/reduced_divider.sv
// reduced_divider: multi-cycle signed divider with divisor pre-shift around one shared log2 unit.
// Define REDUCED_DIVIDER_ROUND_EN for round-half-away-from-zero instead of truncation.
module reduced_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DBITS = DIV_DBITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] num,
    input  logic [WIDTH-1:0] den,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quot,
    output logic             div0,
    output logic             sat
);
    localparam int EW = $clog2(WIDTH + 1);
    localparam int W1 = WIDTH + 1;
    localparam logic [WIDTH-1:0] QMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] QMIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_t state_q;
    logic [WIDTH-1:0] a_q, d_q, q_q, quot_q;
    logic [DBITS:0] r_q;
    logic [EW-1:0] i_q, e;
    logic sign_q, nneg_q, out_valid_q, div0_q, sat_q;
    logic [WIDTH-1:0] lg_in, quot_d;
    logic [DBITS:0] rp_d;
    logic [WIDTH:0] mag_d;
    logic ge_d, sat_d;
    int s;
    assign lg_in = (state_q == LOGD) ? d_q : a_q;
    log2 #(.W(WIDTH)) u_log2 (.x_i(lg_in), .e_o(e));
    assign s = shift_amt(int'(e), DBITS);
    // remainder stays below B < 2^DBITS, so dropping its top bit before the shift is lossless
    assign rp_d = {r_q[DBITS-1:0], a_q[i_q]};
    assign ge_d = rp_d >= d_q[DBITS:0];
`ifdef REDUCED_DIVIDER_ROUND_EN
    assign mag_d = {1'b0, q_q} + W1'({r_q, 1'b0} >= {1'b0, d_q[DBITS:0]});
`else
    assign mag_d = {1'b0, q_q};
`endif
    assign sat_d = !div0_q && !sign_q && (mag_d > {1'b0, QMAX});
    assign quot_d = div0_q ? (nneg_q ? QMIN : QMAX) :
                    sat_d ? QMAX :
                    sign_q ? -mag_d[WIDTH-1:0] : mag_d[WIDTH-1:0];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            i_q         <= '0;
            quot_q      <= '0;
            sign_q      <= 1'b0;
            nneg_q      <= 1'b0;
            out_valid_q <= 1'b0;
            div0_q      <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= num[WIDTH-1] ? -num : num;
                    d_q     <= den[WIDTH-1] ? -den : den;
                    sign_q  <= num[WIDTH-1] ^ den[WIDTH-1];
                    nneg_q  <= num[WIDTH-1];
                    div0_q  <= 1'b0;
                    sat_q   <= 1'b0;
                    state_q <= LOGD;
                end
                LOGD: if (e == '0) begin
                    div0_q  <= 1'b1;
                    state_q <= FIN;
                end else begin
                    a_q     <= a_q >> s;
                    d_q     <= d_q >> s;
                    state_q <= LOGN;
                end
                LOGN: begin
                    r_q     <= '0;
                    q_q     <= '0;
                    i_q     <= e - 1'b1;
                    state_q <= (e == '0) ? FIN : DIV;
                end
                DIV: begin
                    r_q <= ge_d ? rp_d - d_q[DBITS:0] : rp_d;
                    if (ge_d) q_q[i_q] <= 1'b1;
                    if (i_q == '0) state_q <= FIN;
                    else i_q <= i_q - 1'b1;
                end
                FIN: begin
                    quot_q      <= quot_d;
                    sat_q       <= sat_d;
                    out_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign in_ready  = state_q == IDLE;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign div0      = div0_q;
    assign sat       = sat_q;
endmodule

// File: tb/tb_reduced_divider.sv
// tb_reduced_divider: vector table, corner sequences and randomized ops against an arithmetic model.
module tb_reduced_divider;
    import div_pkg::*;
    localparam int W  = 20;
    localparam int DB = 8;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0] num = '0, den = '0;
    logic signed [W-1:0] quot;
    logic in_ready, out_valid, div0, sat;
    int total = 0, bad = 0;

    reduced_divider dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .num(num), .den(den), .out_valid(out_valid), .out_ready(out_ready),
        .quot(quot), .div0(div0), .sat(sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n; int d; int q; bit dz; bit st; int lat;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic int bitlen(input longint x);
        int b = 0;
        while (x > 0) begin
            x = x >> 1;
            b++;
        end
        return b;
    endfunction

    function automatic void model(input int n, input int d, output int q, output bit dz,
                                  output bit st, output int lat);
        longint an, ad, a, b, mq, r;
        int s;
        an = (n < 0) ? -longint'(n) : longint'(n);
        ad = (d < 0) ? -longint'(d) : longint'(d);
        st = 1'b0;
        dz = (d == 0);
        if (dz) begin
            q   = (n < 0) ? int'($signed(MAX_NEG)) : int'(MAX_POS);
            lat = 2;
            return;
        end
        s  = (bitlen(ad) > DB) ? bitlen(ad) - DB : 0;
        a  = an >> s;
        b  = ad >> s;
        mq = a / b;
        r  = a % b;
`ifdef REDUCED_DIVIDER_ROUND_EN
        if (2 * r >= b) mq++;
`endif
        if (((n < 0) == (d < 0)) && mq > 524287) begin
            q  = 524287;
            st = 1'b1;
        end else q = ((n < 0) != (d < 0)) ? -int'(mq) : int'(mq);
        lat = 3 + bitlen(a);
    endfunction

    task automatic start_op(input int n, input int d);
        num      = n[W-1:0];
        den      = d[W-1:0];
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_op(input int n, input int d, output int cyc);
        chk("idle_ready", int'(in_ready), 1);
        start_op(n, d);
        cyc = 0;
        while (!out_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("drop_valid", int'(out_valid), 0);
        chk("ready_back", int'(in_ready), 1);
    endtask

    task automatic check_op(input string tag, input int n, input int d, input int q,
                            input bit dz, input bit st, input int lat);
        int cyc;
        do_op(n, d, cyc);
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_quot"}, int'(quot), q);
        chk({tag, "_div0"}, int'(div0), int'(dz));
        chk({tag, "_sat"}, int'(sat), int'(st));
        release_out();
    endtask

    initial begin
        int q, lat, cyc, n, d;
        bit dz, st;
        int q_hold;
`ifdef REDUCED_DIVIDER_ROUND_EN
        vecs[0] = '{1000, 7, 143, 0, 0, 13};
        vecs[7] = '{-7, 2, -4, 0, 0, 6};
`else
        vecs[0] = '{1000, 7, 142, 0, 0, 13};
        vecs[7] = '{-7, 2, -3, 0, 0, 6};
`endif
        vecs[1] = '{-500000, 3000, -167, 0, 0, 18};
        vecs[2] = '{12345, 0, 524287, 1, 0, 2};
        vecs[3] = '{-5, 0, -524288, 1, 0, 2};
        vecs[4] = '{-524288, -1, 524287, 0, 1, 23};
        vecs[5] = '{0, 9, 0, 0, 0, 3};
        vecs[6] = '{100, 10, 10, 0, 0, 10};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_ready", int'(in_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_quot", int'(quot), 0);
        chk("rst_div0", int'(div0), 0);
        chk("rst_sat", int'(sat), 0);

        foreach (vecs[i])
            check_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].d, vecs[i].q,
                     vecs[i].dz, vecs[i].st, vecs[i].lat);

        do_op(1000, 7, cyc);
        chk("bp_valid", int'(out_valid), 1);
        q_hold = int'(quot);
        chk("bp_quot0", q_hold, vecs[0].q);
        for (int i = 0; i < 20; i++) begin
            num      = 20'd77;
            den      = 20'd3;
            in_valid = i[0];
            @(posedge clk);
            #1;
            chk("bp_quot", int'(quot), q_hold);
            chk("bp_busy", int'(in_ready), 0);
            chk("bp_hold", int'(out_valid), 1);
        end
        in_valid = 1'b0;
        release_out();
        @(posedge clk);
        #1;
        chk("bp_no_accept", int'(in_ready), 1);

        start_op(1000, 7);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("mid_rst_ready", int'(in_ready), 1);
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_quot", int'(quot), 0);
        check_op("after_rst", 100, 10, 10, 0, 0, 10);

        for (int i = 0; i < 200; i++) begin
            n = int'($urandom_range(0, 1048575)) - 524288;
            if (i % 5 == 0) n = int'($urandom_range(0, 2000)) - 1000;
            case ($urandom_range(0, 3))
                0: d = int'($urandom_range(0, 40)) - 20;
                1: d = int'($urandom_range(0, 4000)) - 2000;
                default: d = int'($urandom_range(0, 1048575)) - 524288;
            endcase
            model(n, d, q, dz, st, lat);
            check_op("rand", n, d, q, dz, st, lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
